// File: rtl/collision_scheduler_if.sv
// Frame tick, entity snapshot inputs and delete-command / status outputs of the collision
// scheduler. master = scheduler side, slave = game logic side.
interface collision_scheduler_if #(
    parameter int unsigned MAX_SHOTS     = 3,
    parameter int unsigned MAX_ASTEROIDS = 3,
    parameter int unsigned ENTITY_SIZE   = 34
);
    logic                                 start;
    logic [ENTITY_SIZE-1:0]               ship;
    logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids;
    logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shots;
    logic                                 del_valid;
    logic                                 del_ready;
    logic                                 del_kind;
    logic [9:0]                           del_addr;
    logic                                 ship_hit;
    logic                                 busy;
    logic                                 done;

    modport master (
        input  start, ship, asteroids, shots, del_ready,
        output del_valid, del_kind, del_addr, ship_hit, busy, done
    );

    modport slave (
        output start, ship, asteroids, shots, del_ready,
        input  del_valid, del_kind, del_addr, ship_hit, busy, done
    );
endinterface

// File: rtl/collision_scheduler.sv
// Frame-rate collision sequencer: snapshots the entities on start, then walks ship/asteroid,
// asteroid/shot and shot-bounds checks one per cycle through a single overlap comparator.
module collision_scheduler #(
    parameter int unsigned MAX_SHOTS     = 3,
    parameter int unsigned MAX_ASTEROIDS = 3,
    parameter int unsigned ENTITY_SIZE   = 34,
    parameter int unsigned SHIP_SIZE     = 22,
    parameter int unsigned AST_SIZE      = 22,
    parameter int unsigned SHOT_SIZE     = 2,
    parameter int unsigned SCREEN_W      = 320,
    parameter int unsigned SCREEN_H      = 240
) (
    input logic                   clk,
    input logic                   reset_n,
    collision_scheduler_if.master bus
);
    localparam int unsigned MAX_SLOTS = (MAX_ASTEROIDS > MAX_SHOTS) ? MAX_ASTEROIDS : MAX_SHOTS;
    localparam int unsigned IDX_W     = (MAX_SLOTS > 2) ? $clog2(MAX_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_AST  = IDX_W'(MAX_ASTEROIDS - 1);
    localparam logic [IDX_W-1:0] LAST_SHOT = IDX_W'(MAX_SHOTS - 1);

    typedef enum logic [2:0] {StIdle, StShip, StPair, StBounds, StEmit, StDone} state_e;

    state_e                               state;
    logic [ENTITY_SIZE-1:0]               ship_snap;
    logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] ast_snap;
    logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shot_snap;
    logic [MAX_ASTEROIDS-1:0]             ast_kill;
    logic [MAX_SHOTS-1:0]                 shot_kill;
    logic                                 ship_chk;
    logic [IDX_W-1:0]                     ast_idx;
    logic [IDX_W-1:0]                     shot_idx;
    logic                                 pend_ast;
    logic                                 from_bounds;

    logic [ENTITY_SIZE-1:0] ast_sel;
    logic [ENTITY_SIZE-1:0] shot_sel;
    logic [10:0]            ax, ay, asz, bx, by, bsz;
    logic                   overlap;
    logic                   off_screen;

    // Shared comparator: ship vs asteroid in StShip, asteroid vs shot otherwise.
    always_comb begin
        ast_sel  = ast_snap[int'(ast_idx) * ENTITY_SIZE +: ENTITY_SIZE];
        shot_sel = shot_snap[int'(shot_idx) * ENTITY_SIZE +: ENTITY_SIZE];
        if (state == StShip) begin
            ax  = {1'b0, ship_snap[15:6]};
            ay  = {1'b0, ship_snap[25:16]};
            asz = 11'(SHIP_SIZE);
            bx  = {1'b0, ast_sel[15:6]};
            by  = {1'b0, ast_sel[25:16]};
            bsz = 11'(AST_SIZE);
        end else begin
            ax  = {1'b0, ast_sel[15:6]};
            ay  = {1'b0, ast_sel[25:16]};
            asz = 11'(AST_SIZE);
            bx  = {1'b0, shot_sel[15:6]};
            by  = {1'b0, shot_sel[25:16]};
            bsz = 11'(SHOT_SIZE);
        end
        overlap    = (ax < bx + bsz) && (bx < ax + asz) && (ay < by + bsz) && (by < ay + asz);
        off_screen = ({1'b0, shot_sel[15:6]} >= 11'(SCREEN_W)) ||
                     ({1'b0, shot_sel[25:16]} >= 11'(SCREEN_H));
    end

    // Only position and alive bits of the snapshots matter; the rest is dropped in synthesis.
    logic unused_bits;
    assign unused_bits = ^{ship_snap, ast_sel, shot_sel};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            ship_snap     <= '0;
            ast_snap      <= '0;
            shot_snap     <= '0;
            ast_kill      <= '0;
            shot_kill     <= '0;
            ship_chk      <= 1'b0;
            ast_idx       <= '0;
            shot_idx      <= '0;
            pend_ast      <= 1'b0;
            from_bounds   <= 1'b0;
            bus.del_valid <= 1'b0;
            bus.del_kind  <= 1'b0;
            bus.del_addr  <= '0;
            bus.ship_hit  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.ship_hit <= 1'b0;
            bus.done     <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        ship_snap <= bus.ship;
                        ast_snap  <= bus.asteroids;
                        shot_snap <= bus.shots;
                        for (int k = 0; k < MAX_ASTEROIDS; k++) begin
                            ast_kill[k] <= ~bus.asteroids[k * ENTITY_SIZE];
                        end
                        for (int k = 0; k < MAX_SHOTS; k++) begin
                            shot_kill[k] <= ~bus.shots[k * ENTITY_SIZE];
                        end
                        ship_chk <= bus.ship[0];
                        ast_idx  <= '0;
                        shot_idx <= '0;
                        bus.busy <= 1'b1;
                        state    <= StShip;
                    end
                end
                StShip: begin
                    if (ship_chk && !ast_kill[ast_idx] && overlap) begin
                        bus.ship_hit <= 1'b1;
                        ship_chk     <= 1'b0;
                    end
                    if (ast_idx == LAST_AST) begin
                        ast_idx <= '0;
                        state   <= StPair;
                    end else begin
                        ast_idx <= ast_idx + 1'b1;
                    end
                end
                StPair: begin
                    if (!ast_kill[ast_idx] && !shot_kill[shot_idx] && overlap) begin
                        ast_kill[ast_idx]   <= 1'b1;
                        shot_kill[shot_idx] <= 1'b1;
                        bus.del_valid       <= 1'b1;
                        bus.del_kind        <= 1'b0;
                        bus.del_addr        <= 10'(shot_idx);
                        pend_ast            <= 1'b1;
                        from_bounds         <= 1'b0;
                        state               <= StEmit;
                    end else if (shot_idx == LAST_SHOT) begin
                        shot_idx <= '0;
                        if (ast_idx == LAST_AST) begin
                            state <= StBounds;
                        end else begin
                            ast_idx <= ast_idx + 1'b1;
                        end
                    end else begin
                        shot_idx <= shot_idx + 1'b1;
                    end
                end
                StBounds: begin
                    if (!shot_kill[shot_idx] && off_screen) begin
                        shot_kill[shot_idx] <= 1'b1;
                        bus.del_valid       <= 1'b1;
                        bus.del_kind        <= 1'b0;
                        bus.del_addr        <= 10'(shot_idx);
                        pend_ast            <= 1'b0;
                        from_bounds         <= 1'b1;
                        state               <= StEmit;
                    end else if (shot_idx == LAST_SHOT) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= StDone;
                    end else begin
                        shot_idx <= shot_idx + 1'b1;
                    end
                end
                StEmit: begin
                    if (bus.del_ready) begin
                        if (pend_ast) begin
                            // Second command of a pair hit: asteroid follows its shot.
                            bus.del_kind <= 1'b1;
                            bus.del_addr <= 10'(ast_idx);
                            pend_ast     <= 1'b0;
                        end else begin
                            bus.del_valid <= 1'b0;
                            bus.del_kind  <= 1'b0;
                            bus.del_addr  <= '0;
                            if (from_bounds) begin
                                if (shot_idx == LAST_SHOT) begin
                                    bus.busy <= 1'b0;
                                    bus.done <= 1'b1;
                                    state    <= StDone;
                                end else begin
                                    shot_idx <= shot_idx + 1'b1;
                                    state    <= StBounds;
                                end
                            end else if (shot_idx == LAST_SHOT) begin
                                shot_idx <= '0;
                                if (ast_idx == LAST_AST) begin
                                    state <= StBounds;
                                end else begin
                                    ast_idx <= ast_idx + 1'b1;
                                    state   <= StPair;
                                end
                            end else begin
                                shot_idx <= shot_idx + 1'b1;
                                state    <= StPair;
                            end
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: directed vector table, reset/busy-start sequences and
// randomized frames checked against a cycle-level event model.
module tb_collision_scheduler;
    localparam int unsigned NS = 3;
    localparam int unsigned NA = 3;
    localparam int unsigned ES = 34;
    localparam int unsigned AW = NA * ES;
    localparam int unsigned SW = NS * ES;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    collision_scheduler_if #(.MAX_SHOTS(NS), .MAX_ASTEROIDS(NA), .ENTITY_SIZE(ES)) bus ();

    collision_scheduler #(.MAX_SHOTS(NS), .MAX_ASTEROIDS(NA), .ENTITY_SIZE(ES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    bit rdy [256];

    int obs_n, obs_hit_n, obs_hit_cyc, obs_done, obs_busy;
    int obs_kind [16];
    int obs_addr [16];
    int obs_cyc  [16];

    int m_n, m_hit_n, m_hit_cyc, m_done;
    int m_kind [16];
    int m_addr [16];
    int m_cyc  [16];

    typedef struct {
        logic [ES-1:0] ship;
        logic [AW-1:0] ast;
        logic [SW-1:0] shot;
        int stall_from;
        int stall_len;
        int extra_start;
        int exp_n;
        int exp_d0;
        int exp_d1;
        int exp_hit_n;
        int exp_hit_cyc;
        int exp_done;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [ES-1:0] ent(input bit alive, input int x, input int y,
                                          input logic [ES-1:0] junk);
        logic [ES-1:0] w;
        w = junk;
        w[0] = alive;
        w[15:6] = x[9:0];
        w[25:16] = y[9:0];
        return w;
    endfunction

    function automatic logic [AW-1:0] pack3(input logic [ES-1:0] e0, input logic [ES-1:0] e1,
                                            input logic [ES-1:0] e2);
        return {e2, e1, e0};
    endfunction

    function automatic vec_t mkvec(input logic [ES-1:0] sh, input logic [AW-1:0] as,
                                   input logic [SW-1:0] so, input int sf, input int sl,
                                   input int xs, input int n, input int d0, input int d1,
                                   input int hn, input int hc, input int dn);
        vec_t v;
        v.ship = sh; v.ast = as; v.shot = so;
        v.stall_from = sf; v.stall_len = sl; v.extra_start = xs;
        v.exp_n = n; v.exp_d0 = d0; v.exp_d1 = d1;
        v.exp_hit_n = hn; v.exp_hit_cyc = hc; v.exp_done = dn;
        return v;
    endfunction

    function automatic int fx(input logic [ES-1:0] w);
        return int'(w[15:6]);
    endfunction

    function automatic int fy(input logic [ES-1:0] w);
        return int'(w[25:16]);
    endfunction

    function automatic bit boxes_overlap(input int ax, input int ay, input int as,
                                         input int bx, input int by, input int bs);
        return (ax < bx + bs) && (bx < ax + as) && (ay < by + bs) && (by < ay + as);
    endfunction

    function automatic int accept_cycle(input int from);
        int c = from;
        while (c < 255 && !rdy[c]) c++;
        return c;
    endfunction

    task automatic m_push(input int kind, input int addr, input int cyc);
        if (m_n < 16) begin
            m_kind[m_n] = kind; m_addr[m_n] = addr; m_cyc[m_n] = cyc;
        end
        m_n++;
    endtask

    // Timeline model: one cycle per check, one cycle per command plus ready stalls.
    task automatic model_scan(input logic [ES-1:0] sh, input logic [AW-1:0] as,
                              input logic [SW-1:0] so);
        logic [ES-1:0] a [NA];
        logic [ES-1:0] s [NS];
        bit ak [NA];
        bit sk [NS];
        bit chk;
        int cyc;
        for (int k = 0; k < NA; k++) begin a[k] = as[k*ES +: ES]; ak[k] = !a[k][0]; end
        for (int k = 0; k < NS; k++) begin s[k] = so[k*ES +: ES]; sk[k] = !s[k][0]; end
        chk = sh[0]; cyc = 0; m_n = 0; m_hit_n = 0; m_hit_cyc = 0;
        for (int i = 0; i < NA; i++) begin
            cyc++;
            if (chk && !ak[i] && boxes_overlap(fx(sh), fy(sh), 22, fx(a[i]), fy(a[i]), 22)) begin
                m_hit_n++; m_hit_cyc = cyc + 1; chk = 0;
            end
        end
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NS; j++) begin
                cyc++;
                if (!ak[i] && !sk[j] &&
                    boxes_overlap(fx(a[i]), fy(a[i]), 22, fx(s[j]), fy(s[j]), 2)) begin
                    ak[i] = 1; sk[j] = 1;
                    cyc = accept_cycle(cyc + 1); m_push(0, j, cyc);
                    cyc = accept_cycle(cyc + 1); m_push(1, i, cyc);
                end
            end
        end
        for (int j = 0; j < NS; j++) begin
            cyc++;
            if (!sk[j] && (fx(s[j]) >= 320 || fy(s[j]) >= 240)) begin
                sk[j] = 1;
                cyc = accept_cycle(cyc + 1); m_push(0, j, cyc);
            end
        end
        m_done = cyc + 1;
    endtask

    // Start a scan, then record accepted deletes, ship hits, busy and done per cycle.
    task automatic run_scan(input logic [ES-1:0] sh, input logic [AW-1:0] as,
                            input logic [SW-1:0] so, input int extra_start);
        int prev_stall, prev_k, prev_a;
        bus.ship = sh; bus.asteroids = as; bus.shots = so;
        bus.start = 1'b1; bus.del_ready = rdy[0];
        @(posedge clk); #1;
        obs_n = 0; obs_hit_n = 0; obs_hit_cyc = 0; obs_done = 0; obs_busy = 0; prev_stall = 0;
        prev_k = 0; prev_a = 0;
        for (int k = 0; k < 16; k++) begin obs_kind[k] = -1; obs_addr[k] = -1; obs_cyc[k] = -1; end
        for (int c = 1; c < 200 && obs_done == 0; c++) begin
            bus.start = (c == extra_start);
            bus.del_ready = rdy[c];
            if (prev_stall != 0)
                check($sformatf("stall_hold_c%0d", c),
                      int'({bus.del_valid, bus.del_kind, bus.del_addr}),
                      int'({1'b1, prev_k[0], prev_a[9:0]}));
            prev_stall = int'(bus.del_valid && !bus.del_ready);
            prev_k = int'(bus.del_kind); prev_a = int'(bus.del_addr);
            if (bus.busy) obs_busy++;
            if (bus.ship_hit) begin obs_hit_n++; obs_hit_cyc = c; end
            if (bus.del_valid && bus.del_ready) begin
                if (obs_n < 16) begin
                    obs_kind[obs_n] = int'(bus.del_kind);
                    obs_addr[obs_n] = int'(bus.del_addr);
                    obs_cyc[obs_n] = c;
                end
                obs_n++;
            end
            if (bus.done) obs_done = c;
            bus.ship = ES'({$urandom(), $urandom()});
            bus.asteroids = AW'({$urandom(), $urandom(), $urandom(), $urandom()});
            bus.shots = SW'({$urandom(), $urandom(), $urandom(), $urandom()});
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        if (obs_done == 0) check("done_timeout", 0, 1);
        check("done_single", int'({bus.done, bus.busy}), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, int'(bus.del_valid), 0);
        check({tag, "_kind"}, int'(bus.del_kind), 0);
        check({tag, "_addr"}, int'(bus.del_addr), 0);
        check({tag, "_ship_hit"}, int'(bus.ship_hit), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ES-1:0] base_ship, hit_ship, dead_ship, z, sh;
        logic [AW-1:0] base_ast, pair_ast, ship_ast, as;
        logic [SW-1:0] base_shot, pair_shot, ship_shot, oob_shot, so;
        int waited;
        z = '0;
        base_ship = ent(1, 160, 120, z);
        hit_ship  = ent(1, 50, 50, z);
        dead_ship = ent(0, 50, 50, z);
        base_ast  = pack3(ent(1, 100, 100, z), ent(1, 200, 50, z), ent(1, 10, 200, z));
        pair_ast  = pack3(ent(1, 250, 200, z), ent(1, 100, 100, z), ent(1, 105, 105, z));
        ship_ast  = pack3(ent(1, 40, 40, z), ent(1, 200, 50, z), ent(1, 60, 60, z));
        base_shot = pack3(ent(1, 0, 0, z), ent(1, 300, 10, z), ent(1, 50, 50, z));
        pair_shot = pack3(ent(1, 0, 0, z), ent(1, 300, 10, z), ent(1, 110, 110, z));
        ship_shot = pack3(ent(1, 0, 0, z), ent(1, 300, 10, z), ent(1, 150, 150, z));
        oob_shot  = pack3(ent(1, 320, 5, z), ent(1, 5, 239, z), ent(1, 5, 240, z));

        // ship, ast, shot, stall_from, stall_len, extra_start, n, d0, d1, hits, hit_cyc, done
        vecs[0] = mkvec(base_ship, base_ast, base_shot, 0, 0, 0, 0, 0, 0, 0, 0, 16);
        vecs[1] = mkvec(base_ship, pair_ast, pair_shot, 0, 0, 0, 2, 2, 1025, 0, 0, 18);
        vecs[2] = mkvec(base_ship, pair_ast, pair_shot, 10, 5, 0, 2, 2, 1025, 0, 0, 23);
        vecs[3] = mkvec(hit_ship, ship_ast, ship_shot, 0, 0, 0, 0, 0, 0, 1, 2, 16);
        vecs[4] = mkvec(dead_ship, ship_ast, ship_shot, 0, 0, 0, 0, 0, 0, 0, 0, 16);
        vecs[5] = mkvec(base_ship, base_ast, oob_shot, 0, 0, 0, 2, 0, 2, 0, 0, 18);
        vecs[6] = mkvec(base_ship, base_ast, base_shot, 0, 0, 5, 0, 0, 0, 0, 0, 16);

        bus.start = 1'b0; bus.del_ready = 1'b1;
        bus.ship = '0; bus.asteroids = '0; bus.shots = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int c = 0; c < 256; c++)
                rdy[c] = !(c >= vecs[v].stall_from && c < vecs[v].stall_from + vecs[v].stall_len);
            run_scan(vecs[v].ship, vecs[v].ast, vecs[v].shot, vecs[v].extra_start);
            check($sformatf("v%0d_ndel", v), obs_n, vecs[v].exp_n);
            if (vecs[v].exp_n > 0)
                check($sformatf("v%0d_del0", v), obs_kind[0] * 1024 + obs_addr[0], vecs[v].exp_d0);
            if (vecs[v].exp_n > 1)
                check($sformatf("v%0d_del1", v), obs_kind[1] * 1024 + obs_addr[1], vecs[v].exp_d1);
            check($sformatf("v%0d_hits", v), obs_hit_n, vecs[v].exp_hit_n);
            check($sformatf("v%0d_hit_cyc", v), obs_hit_cyc, vecs[v].exp_hit_cyc);
            check($sformatf("v%0d_done_cyc", v), obs_done, vecs[v].exp_done);
            check($sformatf("v%0d_busy_cycles", v), obs_busy, vecs[v].exp_done - 1);
        end

        // Reset while a delete is stalled mid-scan, then a clean full scan.
        for (int c = 0; c < 256; c++) rdy[c] = 1'b0;
        bus.ship = base_ship; bus.asteroids = pair_ast; bus.shots = pair_shot;
        bus.del_ready = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waited = 0;
        while (!bus.del_valid && waited < 40) begin @(posedge clk); #1; waited++; end
        check("mid_valid", int'(bus.del_valid), 1);
        check("mid_addr", int'(bus.del_addr), 2);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 256; c++) rdy[c] = 1'b1;
        run_scan(base_ship, base_ast, base_shot, 0);
        check("post_rst_ndel", obs_n, 0);
        check("post_rst_done", obs_done, 16);
        check("post_rst_busy", obs_busy, 15);

        // Randomized frames clustered so overlaps, edge touches and bounds hits are common.
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 256; c++) rdy[c] = (c >= 150) || ($urandom_range(0, 9) < 7);
            sh = ent($urandom_range(0, 3) != 0, $urandom_range(0, 90), $urandom_range(0, 90),
                     ES'({$urandom(), $urandom()}));
            as = '0;
            so = '0;
            for (int k = 0; k < NA; k++)
                as[k*ES +: ES] = ent($urandom_range(0, 4) != 0, $urandom_range(0, 90),
                                     $urandom_range(0, 90), ES'({$urandom(), $urandom()}));
            for (int k = 0; k < NS; k++)
                so[k*ES +: ES] = ent($urandom_range(0, 4) != 0,
                                     ($urandom_range(0, 3) == 0) ? $urandom_range(318, 322)
                                                                 : $urandom_range(0, 90),
                                     ($urandom_range(0, 3) == 0) ? $urandom_range(238, 242)
                                                                 : $urandom_range(0, 90),
                                     ES'({$urandom(), $urandom()}));
            model_scan(sh, as, so);
            run_scan(sh, as, so, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 14) : 0);
            check($sformatf("rnd%0d_ndel", t), obs_n, m_n);
            for (int k = 0; k < m_n && k < 16; k++)
                check($sformatf("rnd%0d_del%0d", t, k),
                      obs_kind[k] * 1000000 + obs_addr[k] * 1000 + obs_cyc[k],
                      m_kind[k] * 1000000 + m_addr[k] * 1000 + m_cyc[k]);
            check($sformatf("rnd%0d_hits", t), obs_hit_n, m_hit_n);
            check($sformatf("rnd%0d_hit_cyc", t), obs_hit_cyc, m_hit_cyc);
            check($sformatf("rnd%0d_done", t), obs_done, m_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Frame-rate sequencer for collision detection in the asteroids game.
- On each frame tick it snapshots the ship, asteroid and shot entity vectors, then walks every check pair through a single shared overlap comparator, one pair per cycle.
- It issues delete commands to the entity manager over a valid/ready handshake and reports ship hits to game-state logic.
- It replaces free-running, every-cycle comparison with a deterministic, stallable scan.

Parameters:
- MAX_SHOTS, 3: shot slots scanned.
- MAX_ASTEROIDS, 3: asteroid slots scanned.
- ENTITY_SIZE, 34: bits per entity word. Bit 0 = alive, [15:6] = x, [25:16] = y.
- SHIP_SIZE, 22: ship box edge in pixels.
- AST_SIZE, 22: asteroid box edge in pixels.
- SHOT_SIZE, 2: shot box edge in pixels.
- SCREEN_W, 320: x limit.
- SCREEN_H, 240: y limit.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  frame tick; one-cycle pulse begins a scan
- ship  in  ENTITY_SIZE  ship entity word
- asteroids  in  MAX_ASTEROIDS*ENTITY_SIZE  packed asteroid words, slot i at [i*ENTITY_SIZE +: ENTITY_SIZE]
- shots  in  MAX_SHOTS*ENTITY_SIZE  packed shot words, same packing
- del_valid  out  1  delete command valid
- del_ready  in  1  entity manager accepts command
- del_kind  out  1  0 = shot, 1 = asteroid
- del_addr  out  10  slot index to delete
- ship_hit  out  1  one-cycle pulse, ship overlaps an asteroid
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end

Behaviour:
- Reset:
  - State goes to IDLE.
  - del_valid, del_kind, del_addr, ship_hit, busy and done are all 0.
  - Snapshot registers and kill masks are cleared.
  - Assertion mid-scan aborts immediately; any pending delete is dropped.
- IDLE:
  - start=1 latches ship, asteroids and shots into snapshot registers.
  - Asteroid/shot kill masks are loaded from the inverted alive bits.
  - The ship-check flag is set from ship bit 0.
  - Next state is SHIP; busy=1 from the next cycle.
  - start while busy is ignored.
- Overlap test (shared comparator, combinational on the selected pair):
  - Hit iff ax < bx+bw && bx < ax+aw && ay < by+bh && by < ay+ah.
  - All operands are zero-extended to 11 bits, so no wrap occurs.
- SHIP state: i = 0..MAX_ASTEROIDS-1, ship vs asteroid i.
  - Skipped (cycle still consumed) if the asteroid is killed or the ship-check flag is clear.
  - On hit: ship_hit pulses next cycle and the ship-check flag clears, so there is at most one ship_hit per scan.
  - No delete is issued for a ship hit.
- PAIR state: i outer 0..MAX_ASTEROIDS-1, j inner 0..MAX_SHOTS-1, asteroid i vs shot j.
  - Skipped if either entity is killed.
  - On hit, both kill bits are set and the block enters EMIT with two queued commands: shot j first, then asteroid i.
- BOUNDS state: j = 0..MAX_SHOTS-1 over shots not killed.
  - Condition is x >= SCREEN_W or y >= SCREEN_H.
  - On a match: set the kill bit, then EMIT a single shot j delete.
- EMIT:
  - del_valid=1 with del_kind/del_addr stable until del_valid && del_ready at a rising edge.
  - Then the next queued command is presented, or the scan resumes at the following pair.
  - The scan index is held while in EMIT.
  - del_ready high on the first cycle gives a back-to-back transfer: one cycle per command, no bubble.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then return to IDLE.
- Timing with no hits:
  - Scan takes MAX_ASTEROIDS + MAX_ASTEROIDS*MAX_SHOTS + MAX_SHOTS cycles (15 at defaults).
  - done is high on the 16th cycle after the start sample.
  - Each accepted command adds exactly one cycle plus any del_ready stall.
- Input changes during a scan have no effect; only the snapshot is used.

Test Plan:
- No hits:
  - Stimulus: all alive, asteroids at (100,100), (200,50), (10,200); shots at (0,0), (300,10), (50,50); ship at (160,120); del_ready=1; start pulse.
  - Required: no del_valid; busy high for 15 cycles; done pulse at cycle 16.
- Pair hit:
  - Stimulus: asteroid 1 at (100,100), shot 2 at (110,110), del_ready=1.
  - Required: del_valid sequence is (kind 0, addr 2) then (kind 1, addr 1) on consecutive cycles; done at cycle 18.
  - Also required: shot 2 is not checked against asteroid 2 and does not appear in BOUNDS.
- Backpressure:
  - Stimulus: same as the pair-hit case with del_ready=0 for 5 cycles.
  - Required: del_addr=2 held stable for all 5 stall cycles; the scan does not advance; done is delayed by 5 cycles.
- Ship collision:
  - Stimulus: ship at (50,50); asteroids 0 and 2 overlap it.
  - Required: a single ship_hit pulse during the SHIP phase; no deletes.
  - Repeat with ship bit 0 = 0: no ship_hit.
- Bounds:
  - Stimulus: shot 0 at x=320, shot 1 at y=239, shot 2 at y=240.
  - Required: deletes (0,0) and (0,2) only.
- Reset and busy start:
  - Stimulus: assert reset_n=0 while del_valid=1 in mid-scan.
  - Required: all outputs go to 0 asynchronously; the next start runs a clean full scan.
  - Also: a start pulse while busy leaves done count and timing unchanged.
